// File: rtl/upsample_pkg.sv
// Shared constants and types for the 2x bilinear upsampling core:
// tap weights, rounding, FSM encoding and output quadrant indices.
package upsample_pkg;

    localparam int W_NEAR = 9;
    localparam int W_SIDE = 3;
    localparam int W_FAR  = 1;
    localparam int RND    = 8;
    localparam int SHIFT  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    localparam logic [1:0] IDX_P00 = 2'd0;
    localparam logic [1:0] IDX_P01 = 2'd1;
    localparam logic [1:0] IDX_P10 = 2'd2;
    localparam logic [1:0] IDX_P11 = 2'd3;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/bilinear_mac.sv
// One combinational bilinear tap: 9*near + 3*(side_a+side_b) + far,
// rounded half-up and divided by 16 with an arithmetic shift.
module bilinear_mac
    import upsample_pkg::*;
#(
    parameter int LENGTH = 16,
    parameter int ACC_W  = LENGTH + 5
) (
    input  logic signed [LENGTH-1:0] near_i,
    input  logic signed [LENGTH-1:0] side_a_i,
    input  logic signed [LENGTH-1:0] side_b_i,
    input  logic signed [LENGTH-1:0] far_i,
    output logic signed [LENGTH-1:0] q_o
);

    localparam logic signed [ACC_W-1:0] K_NEAR = ACC_W'(W_NEAR);
    localparam logic signed [ACC_W-1:0] K_SIDE = ACC_W'(W_SIDE);
    localparam logic signed [ACC_W-1:0] K_FAR  = ACC_W'(W_FAR);
    localparam logic signed [ACC_W-1:0] K_RND  = ACC_W'(RND);

    logic signed [ACC_W-1:0] near_x;
    logic signed [ACC_W-1:0] side_a_x;
    logic signed [ACC_W-1:0] side_b_x;
    logic signed [ACC_W-1:0] far_x;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] rnd;

    assign near_x   = {{(ACC_W-LENGTH){near_i[LENGTH-1]}},   near_i};
    assign side_a_x = {{(ACC_W-LENGTH){side_a_i[LENGTH-1]}}, side_a_i};
    assign side_b_x = {{(ACC_W-LENGTH){side_b_i[LENGTH-1]}}, side_b_i};
    assign far_x    = {{(ACC_W-LENGTH){far_i[LENGTH-1]}},    far_i};

    assign acc = K_NEAR * near_x + K_SIDE * (side_a_x + side_b_x) + K_FAR * far_x;
    assign rnd = (acc + K_RND) >>> SHIFT;

    // Weights sum to 16, so the rounded result always fits back in LENGTH bits.
    assign q_o = rnd[LENGTH-1:0];

    logic unused_rnd_hi;
    assign unused_rnd_hi = ^rnd[ACC_W-1:LENGTH];

endmodule

// File: rtl/upsample_bilinear_core.sv
// Accepts a 2x2 pixel window, computes its four 2x bilinear upsampled pixels
// at once, then streams them out one per beat on a valid/ready interface.
module upsample_bilinear_core
    import upsample_pkg::*;
#(
    parameter int LENGTH = 16,
    parameter int ACC_W  = LENGTH + 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LENGTH-1:0] p00,
    input  logic [LENGTH-1:0] p01,
    input  logic [LENGTH-1:0] p10,
    input  logic [LENGTH-1:0] p11,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LENGTH-1:0] out_data,
    output logic [1:0]        out_idx,
    output logic              out_last,
    output state_e            dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // the producer holds data stable while valid && !ready.

    state_e            state_q;
    logic [1:0]        beat_q;
    logic [1:0]        beat_d;
    logic [LENGTH-1:0] res_q [4];
    logic [LENGTH-1:0] q_d   [4];
    logic              out_valid_q;
    logic [LENGTH-1:0] out_data_q;
    logic [1:0]        out_idx_q;
    logic              out_last_q;

    logic in_accept;
    logic out_fire;
    logic last_fire;

    bilinear_mac #(.LENGTH(LENGTH), .ACC_W(ACC_W)) u_mac_q0 (
        .near_i(p00), .side_a_i(p01), .side_b_i(p10), .far_i(p11), .q_o(q_d[0])
    );
    bilinear_mac #(.LENGTH(LENGTH), .ACC_W(ACC_W)) u_mac_q1 (
        .near_i(p01), .side_a_i(p00), .side_b_i(p11), .far_i(p10), .q_o(q_d[1])
    );
    bilinear_mac #(.LENGTH(LENGTH), .ACC_W(ACC_W)) u_mac_q2 (
        .near_i(p10), .side_a_i(p00), .side_b_i(p11), .far_i(p01), .q_o(q_d[2])
    );
    bilinear_mac #(.LENGTH(LENGTH), .ACC_W(ACC_W)) u_mac_q3 (
        .near_i(p11), .side_a_i(p01), .side_b_i(p10), .far_i(p00), .q_o(q_d[3])
    );

    assign out_fire  = out_valid_q && out_ready;
    assign last_fire = out_fire && (beat_q == IDX_P11);
    // Ready on the final accepted beat lets the next window follow with no bubble.
    assign in_ready  = (state_q == IDLE) || last_fire;
    assign in_accept = in_valid && in_ready;
    assign beat_d    = next_idx(beat_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= IDX_P00;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= IDX_P00;
            out_last_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                res_q[i] <= '0;
            end
        end else if (in_accept) begin
            state_q     <= EMIT;
            beat_q      <= IDX_P00;
            out_valid_q <= 1'b1;
            out_data_q  <= q_d[0];
            out_idx_q   <= IDX_P00;
            out_last_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                res_q[i] <= q_d[i];
            end
        end else if (out_fire) begin
            if (beat_q == IDX_P11) begin
                state_q     <= IDLE;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end else begin
                beat_q     <= beat_d;
                out_data_q <= res_q[beat_d];
                out_idx_q  <= beat_d;
                out_last_q <= (beat_d == IDX_P11);
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_upsample_bilinear_core.sv
// Bench for upsample_bilinear_core: table vectors, multi-cycle corner
// sequences and random windows checked against a separable bilinear model.
module tb_upsample_bilinear_core;
    import upsample_pkg::*;

    localparam int LENGTH = 16;
    localparam int W      = LENGTH + 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [LENGTH-1:0] p00, p01, p10, p11;
    logic              out_valid;
    logic              out_ready;
    logic [LENGTH-1:0] out_data;
    logic [1:0]        out_idx;
    logic              out_last;
    state_e            dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    upsample_bilinear_core #(.LENGTH(LENGTH), .ACC_W(LENGTH + 5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .p00(p00), .p01(p01), .p10(p10), .p11(p11),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic int floor_div16(input int n);
        if (n >= 0) return n / 16;
        return -((-n + 15) / 16);
    endfunction

    // Bilinear weights are separable: 3 on the near row/column, 1 on the far one.
    function automatic logic [LENGTH-1:0] model(input int p [4], input int quad);
        int s;
        int wr, wc;
        s = 0;
        for (int k = 0; k < 4; k++) begin
            wr = ((k / 2) == (quad / 2)) ? 3 : 1;
            wc = ((k % 2) == (quad % 2)) ? 3 : 1;
            s += wr * wc * p[k];
        end
        return LENGTH'(floor_div16(s + 8));
    endfunction

    task automatic push_exp(input logic [LENGTH-1:0] q0, input logic [LENGTH-1:0] q1,
                            input logic [LENGTH-1:0] q2, input logic [LENGTH-1:0] q3);
        exp_q.push_back({1'b0, 2'd0, q0});
        exp_q.push_back({1'b0, 2'd1, q1});
        exp_q.push_back({1'b0, 2'd2, q2});
        exp_q.push_back({1'b1, 2'd3, q3});
    endtask

    task automatic push_model(input logic signed [LENGTH-1:0] a, input logic signed [LENGTH-1:0] b,
                              input logic signed [LENGTH-1:0] c, input logic signed [LENGTH-1:0] d);
        int p [4];
        p[0] = a; p[1] = b; p[2] = c; p[3] = d;
        push_exp(model(p, 0), model(p, 1), model(p, 2), model(p, 3));
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL beat_unexpected actual=%0h required=none", {out_last, out_idx, out_data});
            end else begin
                e = exp_q.pop_front();
                check("beat", 32'({out_last, out_idx, out_data}), 32'(e));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input logic [LENGTH-1:0] a, input logic [LENGTH-1:0] b,
                           input logic [LENGTH-1:0] c, input logic [LENGTH-1:0] d);
        p00 = a; p01 = b; p10 = c; p11 = d;
    endtask

    task automatic send(input logic [LENGTH-1:0] a, input logic [LENGTH-1:0] b,
                        input logic [LENGTH-1:0] c, input logic [LENGTH-1:0] d);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        set_pix(a, b, c, d);
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=0 required=1");
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            if (exp_q.size() == 0 && !out_valid) ok = 1'b1;
            else tick();
        end
        check("drain", 32'(ok), 32'd1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0][LENGTH-1:0] p;
        logic [3:0][LENGTH-1:0] q;
    } vec_t;

    function automatic vec_t mk(input int a, input int b, input int c, input int d,
                                input int q0, input int q1, input int q2, input int q3);
        vec_t v;
        v.p[0] = LENGTH'(a); v.p[1] = LENGTH'(b); v.p[2] = LENGTH'(c); v.p[3] = LENGTH'(d);
        v.q[0] = LENGTH'(q0); v.q[1] = LENGTH'(q1); v.q[2] = LENGTH'(q2); v.q[3] = LENGTH'(q3);
        return v;
    endfunction

    vec_t tbl [7];
    bit   rand_done;

    initial begin
        tbl[0] = mk(100, 100, 100, 100, 100, 100, 100, 100);
        tbl[1] = mk(0, 16, 32, 48, 12, 20, 28, 36);
        tbl[2] = mk(-1, 0, 0, 0, -1, 0, 0, 0);
        tbl[3] = mk(-1, -1, -1, -1, -1, -1, -1, -1);
        tbl[4] = mk(32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767);
        tbl[5] = mk(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768);
        tbl[6] = mk(16, 0, 0, 0, 9, 3, 3, 1);

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        set_pix('0, '0, '0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_state", 32'(dbg_state), 32'(IDLE));

        // table vectors
        for (int t = 0; t < 7; t++) begin
            push_exp(tbl[t].q[0], tbl[t].q[1], tbl[t].q[2], tbl[t].q[3]);
            send(tbl[t].p[0], tbl[t].p[1], tbl[t].p[2], tbl[t].p[3]);
            wait_drain();
        end

        // first beat appears right after the input handshake edge
        push_exp(16'd12, 16'd20, 16'd28, 16'd36);
        in_valid = 1'b1;
        set_pix(16'd0, 16'd16, 16'd32, 16'd48);
        tick();
        in_valid = 1'b0;
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_idx", 32'(out_idx), 32'd0);
        check("lat_data", 32'(out_data), 32'd12);
        check("lat_state", 32'(dbg_state), 32'(EMIT));
        wait_drain();

        // backpressure on beat 1
        push_exp(16'd12, 16'd20, 16'd28, 16'd36);
        send(16'd0, 16'd16, 16'd32, 16'd48);
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_data", 32'(out_data), 32'd20);
            check("bp_idx", 32'(out_idx), 32'd1);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_idx2", 32'(out_idx), 32'd2);
        check("bp_in_ready_b2", 32'(in_ready), 32'd0);
        tick();
        check("bp_idx3", 32'(out_idx), 32'd3);
        check("bp_in_ready_b3", 32'(in_ready), 32'd1);
        wait_drain();

        // back-to-back windows A then B with in_valid held
        push_exp(16'd12, 16'd20, 16'd28, 16'd36);
        push_exp(16'd9, 16'd3, 16'd3, 16'd1);
        in_valid = 1'b1;
        set_pix(16'd0, 16'd16, 16'd32, 16'd48);
        tick();
        set_pix(16'd16, 16'd0, 16'd0, 16'd0);
        for (int k = 0; k < 8; k++) begin
            bit took;
            @(negedge clk);
            check("b2b_valid", 32'(out_valid), 32'd1);
            check("b2b_in_ready", 32'(in_ready), 32'((k == 3) || (k == 7)));
            took = in_valid && in_ready;
            tick();
            if (took) in_valid = 1'b0;
        end
        check("b2b_end_valid", 32'(out_valid), 32'd0);
        check("b2b_hold_data", 32'(out_data), 32'd1);
        wait_drain();

        // asynchronous reset during beat 2
        push_model(16'sd0, 16'sd16, 16'sd32, 16'sd48);
        send(16'd0, 16'd16, 16'd32, 16'd48);
        tick();
        tick();
        check("pre_rst_idx", 32'(out_idx), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_idx", 32'(out_idx), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        push_exp(16'd100, 16'd100, 16'd100, 16'd100);
        send(16'd100, 16'd100, 16'd100, 16'd100);
        check("post_rst_idx", 32'(out_idx), 32'd0);
        check("post_rst_valid", 32'(out_valid), 32'd1);
        wait_drain();

        // randomized windows with random backpressure
        rand_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    logic [LENGTH-1:0] r [4];
                    for (int j = 0; j < 4; j++) begin
                        if ($urandom_range(0, 1) == 1) r[j] = LENGTH'($urandom);
                        else r[j] = LENGTH'($urandom_range(0, 64)) - LENGTH'(32);
                    end
                    push_model(r[0], r[1], r[2], r[3]);
                    send(r[0], r[1], r[2], r[3]);
                    repeat ($urandom_range(0, 2)) tick();
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    tick();
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
